// File: rtl/frame_mem_arbiter.sv
// Shares the single-port ZBT frame memory between VGA scan-out, NTSC capture and the
// transform engine, and rotates the triple-buffered display/capture/process banks.
module frame_mem_arbiter #(
    parameter int LOG_MEM     = 36,
    parameter int LOG_ADDR    = 19,
    parameter int FRAME_WORDS = 153600
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_flag,
    input  logic                vga_flag,
    input  logic                vga_will_request,
    input  logic [9:0]          vga_hcount,
    input  logic [9:0]          vga_vcount,
    output logic [LOG_MEM-1:0]  vga_pixel,
    output logic                done_vga,
    input  logic                ntsc_flag,
    input  logic [9:0]          ntsc_x,
    input  logic [8:0]          ntsc_y,
    input  logic [LOG_MEM-1:0]  ntsc_data,
    output logic                done_ntsc,
    input  logic                proc_req,
    input  logic                proc_we,
    input  logic [17:0]         proc_addr,
    input  logic [LOG_MEM-1:0]  proc_wdata,
    output logic                proc_ack,
    output logic                proc_rvalid,
    output logic [LOG_MEM-1:0]  proc_rdata,
    input  logic                proc_frame_done,
    output logic [LOG_ADDR-1:0] mem_addr,
    output logic                mem_we,
    output logic [LOG_MEM-1:0]  mem_wdata,
    input  logic [LOG_MEM-1:0]  mem_rdata,
    output logic [1:0]          disp_bank,
    output logic [1:0]          cap_bank,
    output logic [1:0]          proc_bank,
    output logic                ntsc_overflow
);

    typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_VGA = 2'd1, TAG_PROC = 2'd2} tag_t;

    logic               ntsc_pend;
    logic [8:0]         ntsc_w_q;
    logic [8:0]         ntsc_y_q;
    logic [LOG_MEM-1:0] ntsc_d_q;
    logic               ready;
    logic               gnt_vga, gnt_ntsc, gnt_proc;
    logic [LOG_ADDR-1:0] nxt_addr;
    logic               nxt_we;
    logic [LOG_MEM-1:0] nxt_wdata;
    tag_t               nxt_tag;
    tag_t               tag_pipe [0:2];

    // Low pixel bit selects the half-word inside a 2-pixel memory word; it never reaches the address.
    logic unused_bits;
    assign unused_bits = &{1'b0, vga_hcount[0], ntsc_x[0]};

    function automatic logic [LOG_ADDR-1:0] base_of(input logic [1:0] b);
        case (b)
            2'd1:    base_of = LOG_ADDR'(FRAME_WORDS);
            2'd2:    base_of = LOG_ADDR'(2 * FRAME_WORDS);
            default: base_of = '0;
        endcase
    endfunction

    // line*320 built from shifts: (v<<8) + (v<<6).
    function automatic logic [LOG_ADDR-1:0] line_off(input logic [9:0] v, input logic [8:0] w);
        line_off = LOG_ADDR'({v, 8'b0}) + LOG_ADDR'({v, 6'b0}) + LOG_ADDR'(w);
    endfunction

    always_comb begin
        gnt_vga  = !reset && vga_flag;
        gnt_ntsc = !reset && !vga_flag && ntsc_pend && !vga_will_request;
        gnt_proc = !reset && !vga_flag && !ntsc_pend && proc_req && !vga_will_request;
    end

    assign done_ntsc = gnt_ntsc;
    assign proc_ack  = gnt_proc;

    always_comb begin
        nxt_addr  = mem_addr;
        nxt_we    = 1'b0;
        nxt_wdata = mem_wdata;
        nxt_tag   = TAG_NONE;
        if (gnt_vga) begin
            nxt_addr = base_of(disp_bank) + line_off(vga_vcount, vga_hcount[9:1]);
            nxt_tag  = TAG_VGA;
        end else if (gnt_ntsc) begin
            nxt_addr  = base_of(cap_bank) + line_off({1'b0, ntsc_y_q}, ntsc_w_q);
            nxt_we    = 1'b1;
            nxt_wdata = ntsc_d_q;
        end else if (gnt_proc) begin
            nxt_addr  = base_of(proc_bank) + LOG_ADDR'(proc_addr);
            nxt_we    = proc_we;
            nxt_wdata = proc_wdata;
            nxt_tag   = proc_we ? TAG_NONE : TAG_PROC;
        end
    end

    // Stage 0 rides with mem_addr; stages 1-2 cover the ZBT's two-cycle read latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            tag_pipe[0] <= TAG_NONE;
            tag_pipe[1] <= TAG_NONE;
            tag_pipe[2] <= TAG_NONE;
        end else begin
            mem_addr    <= nxt_addr;
            mem_we      <= nxt_we;
            mem_wdata   <= nxt_wdata;
            tag_pipe[0] <= nxt_tag;
            tag_pipe[1] <= tag_pipe[0];
            tag_pipe[2] <= tag_pipe[1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done_vga    <= 1'b0;
            vga_pixel   <= '0;
            proc_rvalid <= 1'b0;
            proc_rdata  <= '0;
        end else begin
            done_vga    <= (tag_pipe[2] == TAG_VGA);
            proc_rvalid <= (tag_pipe[2] == TAG_PROC);
            if (tag_pipe[2] == TAG_VGA)  vga_pixel  <= mem_rdata;
            if (tag_pipe[2] == TAG_PROC) proc_rdata <= mem_rdata;
        end
    end

    // A capture arriving in the same cycle the held one drains simply takes its place.
    always_ff @(posedge clock) begin
        if (reset) begin
            ntsc_pend     <= 1'b0;
            ntsc_overflow <= 1'b0;
            ntsc_w_q      <= '0;
            ntsc_y_q      <= '0;
            ntsc_d_q      <= '0;
        end else if (ntsc_flag && (!ntsc_pend || gnt_ntsc)) begin
            ntsc_pend <= 1'b1;
            ntsc_w_q  <= ntsc_x[9:1];
            ntsc_y_q  <= ntsc_y;
            ntsc_d_q  <= ntsc_data;
        end else if (ntsc_flag) begin
            ntsc_overflow <= 1'b1;
        end else if (gnt_ntsc) begin
            ntsc_pend <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            disp_bank <= 2'd0;
            cap_bank  <= 2'd1;
            proc_bank <= 2'd2;
            ready     <= 1'b0;
        end else begin
            if (frame_flag && (ready || proc_frame_done)) begin
                disp_bank <= proc_bank;
                proc_bank <= cap_bank;
                cap_bank  <= disp_bank;
            end
            if (frame_flag)           ready <= 1'b0;
            else if (proc_frame_done) ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Randomized bench for frame_mem_arbiter against a cycle-level reference model of the
// grant rules, bank arithmetic, read latency and bank rotation.
module tb_frame_mem_arbiter;

    localparam int FW   = 153600;
    localparam int NCYC = 3000;

    logic        clock, reset, frame_flag, vga_flag, vga_will_request;
    logic [9:0]  vga_hcount, vga_vcount;
    logic [35:0] vga_pixel;
    logic        done_vga, ntsc_flag, done_ntsc;
    logic [9:0]  ntsc_x;
    logic [8:0]  ntsc_y;
    logic [35:0] ntsc_data;
    logic        proc_req, proc_we, proc_ack, proc_rvalid, proc_frame_done;
    logic [17:0] proc_addr;
    logic [35:0] proc_wdata, proc_rdata;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [35:0] mem_wdata, mem_rdata;
    logic [1:0]  disp_bank, cap_bank, proc_bank;
    logic        ntsc_overflow;

    frame_mem_arbiter dut (
        .clock(clock), .reset(reset), .frame_flag(frame_flag),
        .vga_flag(vga_flag), .vga_will_request(vga_will_request),
        .vga_hcount(vga_hcount), .vga_vcount(vga_vcount),
        .vga_pixel(vga_pixel), .done_vga(done_vga),
        .ntsc_flag(ntsc_flag), .ntsc_x(ntsc_x), .ntsc_y(ntsc_y), .ntsc_data(ntsc_data),
        .done_ntsc(done_ntsc),
        .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_ack(proc_ack), .proc_rvalid(proc_rvalid), .proc_rdata(proc_rdata),
        .proc_frame_done(proc_frame_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .disp_bank(disp_bank), .cap_bank(cap_bank), .proc_bank(proc_bank),
        .ntsc_overflow(ntsc_overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [35:0] rand36();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[35:0];
    endfunction

    // reference model state
    int          m_disp, m_cap, m_proc;
    bit          m_ready, m_pend, m_ovf;
    int          m_px, m_py;
    logic [35:0] m_pd;
    int          exp_addr;
    bit          exp_we;
    logic [35:0] exp_wd, exp_pix, exp_prd;
    bit          rst_prev;
    bit          exp_vv [NCYC+8];
    bit          exp_pv [NCYC+8];
    logic [35:0] rd_hist [NCYC+8];

    // stimulus state
    bit          p_act, p_we, vflag_next, first_done;
    int          p_addr;
    logic [35:0] p_wd;
    int          last_flag = -100;
    int          fv = -100;
    int          g;

    initial begin
        reset = 1'b1; frame_flag = 0; vga_flag = 0; vga_will_request = 0;
        vga_hcount = 0; vga_vcount = 0; ntsc_flag = 0; ntsc_x = 0; ntsc_y = 0; ntsc_data = 0;
        proc_req = 0; proc_we = 0; proc_addr = 0; proc_wdata = 0; proc_frame_done = 0;
        mem_rdata = 0;
        m_disp = 0; m_cap = 1; m_proc = 2;
        exp_addr = 0; exp_we = 0; exp_wd = 0; exp_pix = 0; exp_prd = 0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clock);
            #1;
            cyc = c;
            reset = (c < 3) || (c >= 1200 && c < 1202) || (c == 2400);

            vga_flag   = vflag_next;
            vflag_next = 0;
            if (vga_flag) begin
                last_flag = c;
                if (!first_done && !reset && m_disp == 0) begin
                    vga_hcount = 10'd5; vga_vcount = 10'd2; fv = c; first_done = 1;
                end else begin
                    vga_hcount = 10'($urandom_range(0, 639));
                    vga_vcount = 10'($urandom_range(0, 479));
                end
            end
            vga_will_request = 0;
            if (c + 1 - last_flag >= 4 && $urandom_range(0, 2) == 0) begin
                vga_will_request = 1; vflag_next = 1;
            end

            ntsc_flag = ($urandom_range(0, 4) == 0);
            ntsc_x    = 10'($urandom_range(0, 639));
            ntsc_y    = 9'($urandom_range(0, 479));
            ntsc_data = rand36();

            if (!p_act && $urandom_range(0, 2) == 0) begin
                p_act = 1; p_we = $urandom_range(0, 1) == 1;
                p_addr = $urandom_range(0, FW - 1); p_wd = rand36();
            end
            proc_req = p_act; proc_we = p_we; proc_addr = 18'(p_addr); proc_wdata = p_wd;

            frame_flag      = ($urandom_range(0, 39) == 0);
            proc_frame_done = ($urandom_range(0, 29) == 0);
            mem_rdata  = (c == fv + 3) ? 36'h123456789 : rand36();
            rd_hist[c] = mem_rdata;
            #1;

            if (c > 0) begin
                if (rst_prev) begin
                    exp_pix = 0; exp_prd = 0;
                end else begin
                    if (exp_vv[c]) exp_pix = rd_hist[c-1];
                    if (exp_pv[c]) exp_prd = rd_hist[c-1];
                end
                chk("done_vga", done_vga, exp_vv[c]);
                chk("vga_pixel", vga_pixel, exp_pix);
                chk("proc_rvalid", proc_rvalid, exp_pv[c]);
                chk("proc_rdata", proc_rdata, exp_prd);
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", mem_we, exp_we);
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
                chk("disp_bank", disp_bank, m_disp);
                chk("cap_bank", cap_bank, m_cap);
                chk("proc_bank", proc_bank, m_proc);
                chk("ntsc_overflow", ntsc_overflow, m_ovf);
                if (c == fv + 1) chk("vga_addr_642", mem_addr, 642);
                if (c == fv + 4) chk("vga_pix_const", vga_pixel, 36'h123456789);
            end

            // grant: 0 idle, 1 vga, 2 ntsc, 3 proc
            g = 0;
            if (!reset) begin
                if (vga_flag) g = 1;
                else if (m_pend && !vga_will_request) g = 2;
                else if (p_act && !vga_will_request) g = 3;
            end
            chk("done_ntsc", done_ntsc, g == 2);
            chk("proc_ack", proc_ack, g == 3);

            if (reset) begin
                for (int k = 1; k <= 4; k++) begin
                    exp_vv[c+k] = 0; exp_pv[c+k] = 0;
                end
                exp_addr = 0; exp_we = 0; exp_wd = 0;
                m_pend = 0; m_ovf = 0; m_ready = 0;
                m_disp = 0; m_cap = 1; m_proc = 2;
                rst_prev = 1;
            end else begin
                rst_prev = 0;
                exp_we = 0;
                case (g)
                    1: begin
                        exp_addr = m_disp * FW + vga_vcount * 320 + vga_hcount / 2;
                        exp_vv[c+4] = 1;
                    end
                    2: begin
                        exp_addr = m_cap * FW + m_py * 320 + m_px / 2;
                        exp_we = 1; exp_wd = m_pd;
                    end
                    3: begin
                        exp_addr = m_proc * FW + p_addr;
                        exp_we = p_we; exp_wd = p_wd;
                        if (!p_we) exp_pv[c+4] = 1;
                        p_act = 0;
                    end
                    default: ;
                endcase
                if (ntsc_flag) begin
                    if (!m_pend || g == 2) begin
                        m_pend = 1; m_px = ntsc_x; m_py = ntsc_y; m_pd = ntsc_data;
                    end else begin
                        m_ovf = 1;
                    end
                end else if (g == 2) begin
                    m_pend = 0;
                end
                if (frame_flag) begin
                    if (m_ready || proc_frame_done) begin
                        int od;
                        od = m_disp; m_disp = m_proc; m_proc = m_cap; m_cap = od;
                    end
                    m_ready = 0;
                end else if (proc_frame_done) begin
                    m_ready = 1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/frame_mem_arbiter.md
# frame_mem_arbiter

Shares the single-port pipelined ZBT frame memory between three requesters: VGA scan-out reads (hard real-time), NTSC capture writes, and projective-transform processing reads/writes. Maintains triple-buffered frame banks (display, capture, process) and rotates them at frame boundaries. Sits between the VGA writer, the NTSC capture path, the transform engine, and the ZBT pin driver. All logic runs in the `clock` domain.

## Interface
Parameters:
- `LOG_MEM`, 36: memory word width, two 18-bit YCrCb pixels per word.
- `LOG_ADDR`, 19: memory address width.
- `FRAME_WORDS`, 153600: words per frame bank (320 words x 480 lines).

Ports:
- `clock` in 1: system clock. `reset` in 1: reset, synchronous, active-high.
- `frame_flag` in 1: one-cycle pulse at the start of vertical blank.
- `vga_flag` in 1: VGA read request, at most 1 in 4 cycles.
- `vga_will_request` in 1: asserted exactly one cycle before `vga_flag`.
- `vga_hcount` in 10, `vga_vcount` in 10: pixel coordinates for the VGA read.
- `vga_pixel` out LOG_MEM: read word for VGA. `done_vga` out 1: one-cycle pulse, `vga_pixel` valid.
- `ntsc_flag` in 1, `ntsc_x` in 10, `ntsc_y` in 9, `ntsc_data` in LOG_MEM: capture write request. `done_ntsc` out 1: write issued.
- `proc_req` in 1, `proc_we` in 1, `proc_addr` in 18 (offset within a bank), `proc_wdata` in LOG_MEM: processing request. `proc_ack` out 1: request issued.
- `proc_rvalid` out 1, `proc_rdata` out LOG_MEM: processing read return.
- `proc_frame_done` in 1: one-cycle pulse when the processing frame is complete.
- `mem_addr` out LOG_ADDR, `mem_we` out 1, `mem_wdata` out LOG_MEM, `mem_rdata` in LOG_MEM: ZBT port.
- `disp_bank`, `cap_bank`, `proc_bank` out 2 each: current bank indices.
- `ntsc_overflow` out 1: sticky flag, cleared only by reset.

## Operation
- Bank address: base(bank) = bank*FRAME_WORDS, giving 0, 153600, or 307200. Pixel word = base + vcount*320 + hcount[9:1]. Compute vcount*320 as (v<<8)+(v<<6); no multiplier.
- NTSC holding register: on `ntsc_flag` with the register empty, latch x/y/data and set pending. If `ntsc_flag` arrives while pending, drop the new request and set `ntsc_overflow`.
- Per-cycle grant, fixed priority:
  1. VGA if `vga_flag` is high.
  2. Else NTSC if pending and `vga_will_request` is low.
  3. Else PROC if `proc_req` is high and `vga_will_request` is low.
  4. Else idle: `mem_we`=0, address held.
- VGA read: address from `disp_bank`, `mem_we`=0.
- NTSC write: address from `cap_bank`, `mem_we`=1; pulse `done_ntsc`; clear pending. A new `ntsc_flag` in the same cycle is accepted, not an overflow.
- PROC: address = base(`proc_bank`) + `proc_addr`. Pulse `proc_ack`. The requester holds inputs until ack.
- Read return: a 2-stage tag pipeline (NONE/VGA/PROC) tracks ZBT read latency. Tag VGA → `vga_pixel` <= `mem_rdata` and `done_vga` pulses; `vga_pixel` holds until the next VGA return. Tag PROC → `proc_rdata` is loaded and `proc_rvalid` pulses.
- `proc_frame_done` sets a ready latch. On `frame_flag`:
  - If ready: new disp = old proc, new proc = old cap, new cap = old disp; clear ready.
  - Else: banks are unchanged.
  - `proc_frame_done` and `frame_flag` in the same cycle count as ready, so rotation occurs.
- Banks are always a permutation of {0,1,2}.

## Timing
- Grant decision is combinational from the current-cycle inputs. `mem_addr`/`mem_we`/`mem_wdata` are registered and drive the ZBT on the cycle after the request.
- Read data is valid on `mem_rdata` 2 cycles after `mem_addr` is driven. `done_vga`/`proc_rvalid` assert the cycle after capture, i.e. 4 cycles after `vga_flag`/`proc_ack`.
- `done_ntsc`/`proc_ack` assert in the grant cycle.
- Bank rotation takes effect the cycle after `frame_flag`. Requests granted in the `frame_flag` cycle use the old banks.
- VGA is never delayed: the `vga_will_request` guard keeps the slot free, and a `vga_flag` grant always wins.
- Reset values:
  - All outputs 0 except `disp_bank`=0, `cap_bank`=1, `proc_bank`=2.
  - Tags NONE, pending 0, ready 0, `ntsc_overflow` 0.
  - Reset mid-read discards the in-flight returns; no `done_vga`/`proc_rvalid` is produced for them.

## Test plan
- VGA read at hcount=5, vcount=2, disp_bank=0 → `mem_addr`=642, `mem_we`=0. With `mem_rdata`=36'h123456789 on the third cycle after issue, `done_vga` pulses with `vga_pixel`=36'h123456789 at +4.
- `vga_flag`, pending NTSC, and `proc_req` all in one cycle → VGA granted, then NTSC, then PROC. No grant to NTSC/PROC while `vga_will_request`=1.
- NTSC write (x=639, y=479) with cap_bank=1 → `mem_addr`=153600+153599=307199, `mem_we`=1, `done_ntsc` pulses. A second `ntsc_flag` before the grant sets `ntsc_overflow`=1, which stays set.
- PROC read at `proc_addr`=10, proc_bank=2 → `mem_addr`=307210. `proc_rvalid` pulses 4 cycles after `proc_ack` with the correct data; VGA returns are never routed to PROC.
- `frame_flag` without `proc_frame_done` → banks stay 0/1/2. Then `proc_frame_done` followed by `frame_flag` → disp=2, proc=1, cap=0; another ready+flag → disp=1, proc=0, cap=2.
- Reset asserted with two reads in flight → no `done_vga`/`proc_rvalid` afterwards; banks return to 0/1/2.
